// File: rtl/dot_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dot_update_scheduler
// Purpose  : Buffers processor dot writes and replays them at frame edges.
// Revision : 1.0
// ============================================================================
module dot_update_scheduler #(
  parameter int NUM_DOTS   = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_WIDTH   = 5,
  parameter int MAX_X      = 639,
  parameter int MAX_Y      = 479
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          screenEnd,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_isY,
  input  logic [31:0]                   req_id,
  input  logic [31:0]                   req_loc,
  output logic                          dot_wren,
  output logic                          dot_isY,
  output logic [ID_WIDTH-1:0]           dot_id,
  output logic [9:0]                    dot_loc,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          err_overflow,
  output logic                          err_badid
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ID_WIDTH + 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNAP  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_se_d;
  logic                 w_frame_edge;
  logic                 w_accept;
  logic                 w_id_bad;
  logic                 w_push;
  logic                 w_pop;
  logic [9:0]           w_loc_clamped;
  logic [ENTRY_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [CNT_W-1:0]     r_rem;
  logic                 r_ready;

  assign w_frame_edge = screenEnd & ~r_se_d;
  assign w_accept     = req_valid & r_ready;
  assign w_id_bad     = (req_id >= 32'(NUM_DOTS));
  assign w_push       = w_accept & ~w_id_bad;
  assign w_pop        = (r_state == S_DRAIN);

  // Clamp compares the full 32-bit request so large values never alias.
  always_comb begin
    w_loc_clamped = req_loc[9:0];
    if (req_isY) begin
      if (req_loc > 32'(MAX_Y)) w_loc_clamped = 10'(MAX_Y);
    end else begin
      if (req_loc > 32'(MAX_X)) w_loc_clamped = 10'(MAX_X);
    end
  end

  assign w_entry = {req_isY, req_id[ID_WIDTH-1:0], w_loc_clamped};

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_se_d   <= 1'b0;
    end else begin
      r_se_d  <= screenEnd;
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_edge) w_state_next = S_SNAP;
      S_SNAP:  w_state_next = (r_count == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (r_rem == CNT_W'(1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Snapshot bounds the drain so writes landing mid-drain wait a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
    end else if (r_state == S_SNAP) begin
      r_rem <= r_count;
    end else if (w_pop) begin
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dot_wren   <= 1'b0;
      dot_isY    <= 1'b0;
      dot_id     <= '0;
      dot_loc    <= '0;
      frame_done <= 1'b0;
    end else begin
      dot_wren   <= w_pop;
      frame_done <= (r_state == S_DONE);
      if (w_pop) begin
        {dot_isY, dot_id, dot_loc} <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow <= 1'b0;
      err_badid    <= 1'b0;
    end else begin
      if (req_valid && !r_ready)  err_overflow <= 1'b1;
      if (w_accept && w_id_bad)   err_badid    <= 1'b1;
    end
  end

  assign req_ready = r_ready;
  assign pending   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dot_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_update_scheduler
// Purpose  : Scoreboard bench for dot_update_scheduler with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_dot_update_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        screenEnd = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_isY = 1'b0;
  logic [31:0] req_id = '0;
  logic [31:0] req_loc = '0;
  logic        dot_wren;
  logic        dot_isY;
  logic [4:0]  dot_id;
  logic [9:0]  dot_loc;
  logic        frame_done;
  logic [4:0]  pending;
  logic        err_overflow;
  logic        err_badid;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int fdone_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dot_update_scheduler #(
    .NUM_DOTS(20), .FIFO_DEPTH(16), .ID_WIDTH(5), .MAX_X(639), .MAX_Y(479)
  ) dut (
    .clk(clk), .reset(rst_n), .screenEnd(screenEnd),
    .req_valid(req_valid), .req_ready(req_ready), .req_isY(req_isY),
    .req_id(req_id), .req_loc(req_loc),
    .dot_wren(dot_wren), .dot_isY(dot_isY), .dot_id(dot_id), .dot_loc(dot_loc),
    .frame_done(frame_done), .pending(pending),
    .err_overflow(err_overflow), .err_badid(err_badid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && dot_wren === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected strobe isY=%0d id=%0d loc=%0d",
                 dot_isY, dot_id, dot_loc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({dot_isY, dot_id, dot_loc} !== e) begin
          errors++;
          $display("FAIL strobe: got isY=%0d id=%0d loc=%0d expected isY=%0d id=%0d loc=%0d",
                   dot_isY, dot_id, dot_loc, e[15], e[14:10], e[9:0]);
        end
      end
    end
    if (rst_n && frame_done === 1'b1) fdone_cnt++;
  end

  // Called right after a negedge; returns right after the next negedge.
  task automatic push(input logic isy, input int id, input int loc,
                      input bit acc, input int exp_loc);
    req_valid = 1'b1;
    req_isY   = isy;
    req_id    = 32'(id);
    req_loc   = 32'(loc);
    if (acc) exp_q.push_back({isy, 5'(id), 10'(exp_loc)});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Raises screenEnd for 4 cycles and measures edge-to-frame_done latency.
  task automatic run_frame(input string name, input int k);
    int n;
    n = 0;
    strobe_cnt = 0;
    screenEnd = 1'b1;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (n == 4) screenEnd = 1'b0;
      if (frame_done === 1'b1) break;
    end
    #1;
    chk({name, "_done_latency"}, n, k + 3);
    chk({name, "_strobes"}, strobe_cnt, k);
    @(negedge clk);
    chk({name, "_done_single"}, frame_done, 1'b0);
    screenEnd = 1'b0;
    idle(2);
  endtask

  initial begin
    int n;
    int snap;
    idle(2);
    chk("rst_wren", dot_wren, 0);
    chk("rst_loc", dot_loc, 0);
    chk("rst_id", dot_id, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_badid", err_badid, 0);
    rst_n = 1'b1;
    idle(2);

    // Two writes to the same dot, X then Y
    push(1'b0, 3, 100, 1, 100);
    push(1'b1, 3, 200, 1, 200);
    chk("a_pending", pending, 2);
    run_frame("a", 2);
    chk("a_pending_after", pending, 0);

    // Empty frame
    run_frame("b", 0);

    // Overflow: 16 accepted, 17th dropped
    for (int i = 0; i < 16; i++) push(1'b0, i, 10 * i, 1, 10 * i);
    chk("c_ready_full", req_ready, 0);
    chk("c_pending_full", pending, 16);
    chk("c_ovf_before", err_overflow, 0);
    push(1'b0, 19, 555, 0, 0);
    chk("c_ovf_set", err_overflow, 1);
    chk("c_pending_17", pending, 16);
    run_frame("c", 16);
    chk("c_ready_after", req_ready, 1);

    // Bad ID and clamping
    push(1'b0, 20, 7, 0, 0);
    chk("d_badid", err_badid, 1);
    chk("d_pending_drop", pending, 0);
    push(1'b0, 5, 700, 1, 639);
    push(1'b1, 6, 1000, 1, 479);
    run_frame("d", 2);
    chk("d_ovf_sticky", err_overflow, 1);

    // Second edge during drain is ignored; late entries wait a frame
    for (int i = 0; i < 4; i++) push(1'b0, i, 10 * (i + 1), 1, 10 * (i + 1));
    strobe_cnt = 0;
    snap = fdone_cnt;
    screenEnd = 1'b1;
    idle(2);
    screenEnd = 1'b0;
    push(1'b1, 7, 50, 1, 50);
    screenEnd = 1'b1;
    push(1'b1, 8, 60, 1, 60);
    n = 0;
    while (n < 30 && frame_done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("e_first_frame_seen", frame_done, 1);
    chk("e_strobes", strobe_cnt, 4);
    chk("e_pending_left", pending, 2);
    screenEnd = 1'b0;
    idle(6);
    chk("e_no_extra_frame", fdone_cnt, snap + 1);
    run_frame("e2", 2);

    // Reset in the middle of a drain
    for (int i = 0; i < 5; i++) push(1'b1, 10 + i, i + 1, 1, i + 1);
    strobe_cnt = 0;
    screenEnd = 1'b1;
    n = 0;
    while (n < 30 && strobe_cnt < 2) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("f_two_strobes", strobe_cnt, 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("f_rst_wren", dot_wren, 0);
    chk("f_rst_pending", pending, 0);
    chk("f_rst_ready", req_ready, 1);
    chk("f_rst_loc", dot_loc, 0);
    chk("f_rst_ovf", err_overflow, 0);
    chk("f_rst_badid", err_badid, 0);
    screenEnd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("f_no_more_strobes", strobe_cnt, 2);
    run_frame("f", 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
